// File: rtl/md_pkg.sv
// Shared definitions for the MULT/DIV sequencing controller.
package md_pkg;

    localparam int MD_WIDTH = 32;
    localparam int CNT_W    = $clog2(MD_WIDTH);

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } md_state_t;

endpackage

// File: rtl/md_step.sv
// One unsigned iteration: shift-add multiply or restoring divide step.
module md_step
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               i_op,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_qbit
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_trial;

    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                + (i_acc[0] ? {1'b0, i_opnd} : '0);
        w_trial = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_opnd};
        o_qbit  = 1'b0;
        o_acc   = '0;
        if (i_op == OP_MULT) begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end else begin
            // Quotient bit is returned separately; its slot in o_acc is left 0
            o_qbit = ~w_trial[WIDTH];
            o_acc  = {o_qbit ? w_trial[WIDTH-1:0] : i_acc[2*WIDTH-2:WIDTH-1],
                      i_acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Iterative signed MULT/DIV sequencer owning the HI/LO registers.
module mult_div_ctrl
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    md_state_t          r_state;
    logic               r_op;
    logic               r_zero;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_div_zero;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_div_zero = (i_op == OP_DIV) && (i_b == '0);
    assign w_abs_a    = r_a[WIDTH-1] ? -r_a : r_a;
    assign w_abs_b    = r_b[WIDTH-1] ? -r_b : r_b;
    assign w_prod     = r_neg_res ? -r_acc : r_acc;
    assign w_quo      = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem      = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH]
                                  : r_acc[2*WIDTH-1:WIDTH];

    md_step #(.WIDTH(WIDTH)) u_step (
        .i_op   (r_op),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_acc_nxt),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_MULT;
            r_zero    <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_opnd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_op    <= i_op;
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_zero  <= w_div_zero;
                        r_state <= w_div_zero ? ST_DONE : ST_PREP;
                    end
                end
                ST_PREP: begin
                    // Low half holds the multiplier or dividend being consumed
                    r_acc     <= {{WIDTH{1'b0}},
                                  (r_op == OP_MULT) ? w_abs_b : w_abs_a};
                    r_opnd    <= (r_op == OP_MULT) ? w_abs_a : w_abs_b;
                    r_neg_res <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
                    r_neg_rem <= r_a[WIDTH-1];
                    r_cnt     <= '0;
                    r_state   <= ST_RUN;
                end
                ST_RUN: begin
                    r_acc <= {w_acc_nxt[2*WIDTH-1:1], w_acc_nxt[0] | w_qbit};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1))
                        r_state <= ST_FIXUP;
                end
                ST_FIXUP: begin
                    if (r_op == OP_MULT) begin
                        {r_hi, r_lo} <= w_prod;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_zero  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_DONE);
    assign o_div_zero = o_done & r_zero;
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: directed cases plus randomized ops vs a 64-bit model.
module tb_mult_div_ctrl;

    logic        clock;
    logic        reset;
    logic        i_start;
    logic        i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_busy;
    logic        o_done;
    logic        o_div_zero;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int ntests = 0;
    int nfail  = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_dz;
    int          m_lat;

    mult_div_ctrl #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_div_zero (o_div_zero),
        .o_hi       (o_hi),
        .o_lo       (o_lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed arithmetic on 64-bit integers; division truncates toward zero
    task automatic model(input logic op_v, input logic [31:0] a_v,
                         input logic [31:0] b_v);
        longint sa, sb, p, q, r;
        sa    = longint'($signed(a_v));
        sb    = longint'($signed(b_v));
        m_dz  = 1'b0;
        m_lat = 35;
        if (op_v == 1'b0) begin
            p    = sa * sb;
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (b_v == 32'd0) begin
            m_dz  = 1'b1;
            m_lat = 1;
        end else begin
            q    = sa / sb;
            r    = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
        end
    endtask

    task automatic do_op(input string tag, input logic op_v,
                         input logic [31:0] a_v, input logic [31:0] b_v);
        int   lat;
        int   bcnt;
        logic dz;
        model(op_v, a_v, b_v);
        @(negedge clock);
        i_start = 1'b1;
        i_op    = op_v;
        i_a     = a_v;
        i_b     = b_v;
        @(posedge clock);
        #1;
        i_start = 1'b0;
        lat  = 1;
        bcnt = int'(o_busy);
        while (!o_done && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
            bcnt += int'(o_busy);
        end
        dz = o_div_zero;
        chk({tag, " latency"}, 64'(lat), 64'(m_lat));
        chk({tag, " busy_cycles"}, 64'(bcnt), 64'(m_lat));
        chk({tag, " div_zero"}, 64'(dz), 64'(m_dz));
        chk({tag, " hi"}, 64'(o_hi), 64'(m_hi));
        chk({tag, " lo"}, 64'(o_lo), 64'(m_lo));
        @(posedge clock);
        #1;
        chk({tag, " after_done"}, 64'({o_done, o_busy, o_div_zero}), 64'(0));
    endtask

    initial begin
        int          lat;
        logic        saw;
        logic [31:0] ra, rb;
        logic        rop;
        logic [31:0] corner [5];

        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;

        reset   = 1'b1;
        i_start = 1'b0;
        i_op    = 1'b0;
        i_a     = '0;
        i_b     = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset state", 64'({o_busy, o_done, o_div_zero}), 64'(0));
        chk("reset hi", 64'(o_hi), 64'(0));
        chk("reset lo", 64'(o_lo), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;

        do_op("mult 7*-3", 1'b0, 32'd7, 32'hFFFF_FFFD);
        chk("mult 7*-3 const", 64'({o_hi, o_lo}), 64'hFFFF_FFFF_FFFF_FFEB);

        do_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("div -7/2 const", 64'({o_hi, o_lo}), 64'hFFFF_FFFF_FFFF_FFFD);

        do_op("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div ovf const", 64'({o_hi, o_lo}), 64'h0000_0000_8000_0000);

        do_op("div setup", 1'b1, 32'h0000_0451, 32'h0000_0020);
        do_op("div by zero", 1'b1, 32'd5, 32'd0);
        chk("div0 hi kept", 64'(o_hi), 64'h11);
        chk("div0 lo kept", 64'(o_lo), 64'h22);

        // start held high; operands wander during the operation
        model(1'b0, 32'd3, 32'd4);
        @(negedge clock);
        i_start = 1'b1;
        i_op    = 1'b0;
        i_a     = 32'd3;
        i_b     = 32'd4;
        @(posedge clock);
        #1;
        lat = 1;
        while (!o_done && lat < 100) begin
            i_a = $urandom;
            i_b = $urandom;
            @(posedge clock);
            #1;
            lat++;
        end
        chk("held latency", 64'(lat), 64'(35));
        chk("held result", 64'({o_hi, o_lo}), 64'd12);
        i_a = 32'd5;
        i_b = 32'd6;
        @(posedge clock);
        #1;
        chk("held idle gap", 64'(o_busy), 64'(0));
        @(posedge clock);
        #1;
        chk("held second accepted", 64'(o_busy), 64'(1));
        i_start = 1'b0;
        model(1'b0, 32'd5, 32'd6);
        lat = 1;
        while (!o_done && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("second latency", 64'(lat), 64'(35));
        chk("second result", 64'({o_hi, o_lo}), 64'd30);

        // reset while RUN count is 10
        @(negedge clock);
        i_start = 1'b1;
        i_op    = 1'b0;
        i_a     = 32'h1234;
        i_b     = 32'h5678;
        @(posedge clock);
        #1;
        i_start = 1'b0;
        repeat (11) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("abort busy", 64'({o_busy, o_done}), 64'(0));
        chk("abort hi", 64'(o_hi), 64'(0));
        chk("abort lo", 64'(o_lo), 64'(0));
        m_hi = '0;
        m_lo = '0;
        saw  = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (o_done) saw = 1'b1;
        end
        chk("abort no done", 64'(saw), 64'(0));
        do_op("mult -1*-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mult -1*-1 const", 64'({o_hi, o_lo}), 64'd1);

        for (int i = 0; i < 1000; i++) begin
            rop = 1'($urandom_range(1, 0));
            ra  = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(4, 0)]
                                              : 32'($urandom);
            rb  = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(4, 0)]
                                              : 32'($urandom);
            if ($urandom_range(9, 0) == 0) rb = 32'($urandom_range(15, 0));
            do_op("random", rop, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
